// File: rtl/gray_mon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : gray_mon_pkg                                              |
// | Description : Shared types, default widths and helpers for the Gray     |
// |               code monitor (state enum, Hamming-distance function).     |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package gray_mon_pkg;

  localparam int c_DEF_CBITS = 12;
  localparam int c_DEF_WBITS = 8;

  // Width of the Hamming helper operands; callers zero-extend into it,
  // so count widths up to 32 bits are supported.
  localparam int c_HAM_W = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } gm_state_t;

  // Number of bit positions in which a and b differ.
  function automatic int unsigned gray_hamming(input logic [c_HAM_W-1:0] a,
                                               input logic [c_HAM_W-1:0] b);
    logic [c_HAM_W-1:0] d;
    int unsigned        n;
    d = a ^ b;
    n = 0;
    for (int i = 0; i < c_HAM_W; i++) begin
      n = n + 32'(d[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : gray_to_bin                                               |
// | Description : Combinational Gray-to-binary decoder.                     |
// | Ports       : gray [CBITS] in  - Gray-coded value                       |
// |               bin  [CBITS] out - binary equivalent                      |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module gray_to_bin
  import gray_mon_pkg::*;
#(
  parameter int CBITS = c_DEF_CBITS
) (
  input  logic [CBITS-1:0] gray,
  output logic [CBITS-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position;
  // written per bit so no vector depends on itself.
  for (genvar i = 0; i < CBITS; i++) begin : g_bit
    assign bin[i] = ^gray[CBITS-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/gray_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : gray_monitor                                              |
// | Description : Samples an upstream Gray counter, decodes it to binary,   |
// |               checks step legality and wrap-flag consistency, and       |
// |               counts legal wraps (saturating).                          |
// | Ports       : clk          in  - clock, posedge                         |
// |               rst          in  - async active-high reset                |
// |               gray_in      in  - upstream Gray count [CBITS]            |
// |               sig_in       in  - upstream wrap flag (count == 0)        |
// |               clr          in  - sync clear of fault/wraps/tracking     |
// |               bin_out      out - registered decode of sample [CBITS]    |
// |               valid        out - tracking and checking                  |
// |               err          out - sticky fault                           |
// |               wrap_cnt     out - saturating legal-wrap count [WBITS]    |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module gray_monitor
  import gray_mon_pkg::*;
#(
  parameter int CBITS = c_DEF_CBITS,
  parameter int WBITS = c_DEF_WBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CBITS-1:0] bin_out,
  output logic             valid,
  output logic             err,
  output logic [WBITS-1:0] wrap_cnt
);

  localparam logic [CBITS-1:0] c_BIN_INC  = CBITS'(1);
  localparam logic [WBITS-1:0] c_WRAP_INC = WBITS'(1);

  logic [CBITS-1:0] r_gray_q;
  logic [CBITS-1:0] r_gray_p;
  logic             r_sig_q;
  logic [CBITS-1:0] r_bin_out;
  logic [WBITS-1:0] r_wrap;
  logic             r_primed;
  gm_state_t        r_state;

  logic [CBITS-1:0] w_bin_q;
  logic [CBITS-1:0] w_bin_p;
  logic [CBITS-1:0] w_bin_p_inc;
  int unsigned      w_ham;
  logic             w_step_ok;
  logic             w_sig_ok;
  logic             w_fault;
  logic             w_wrap_evt;
  gm_state_t        w_state_nxt;
  logic [WBITS-1:0] w_wrap_nxt;

  gray_to_bin #(.CBITS(CBITS)) u_dec_q (.gray(r_gray_q), .bin(w_bin_q));
  gray_to_bin #(.CBITS(CBITS)) u_dec_p (.gray(r_gray_p), .bin(w_bin_p));

  // Step legality: a hold is fine (upstream freezes in its own reset);
  // a single-bit change must be exactly +1 modulo 2^CBITS.
  assign w_bin_p_inc = w_bin_p + c_BIN_INC;
  assign w_ham       = gray_hamming(32'(r_gray_q), 32'(r_gray_p));
  assign w_step_ok   = (w_ham == 32'd0) ||
                       ((w_ham == 32'd1) && (w_bin_q == w_bin_p_inc));
  assign w_sig_ok    = (r_sig_q == (r_gray_q == '0));
  assign w_fault     = !(w_step_ok && w_sig_ok);
  // A wrap counts only when arriving at zero, not while holding at zero.
  assign w_wrap_evt  = r_sig_q && (r_gray_p != '0);

  // Sample pipeline and decode register run in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray_q  <= '0;
      r_gray_p  <= '0;
      r_sig_q   <= 1'b0;
      r_bin_out <= '0;
      r_primed  <= 1'b0;
    end else begin
      r_gray_q  <= gray_in;
      r_gray_p  <= r_gray_q;
      r_sig_q   <= sig_in;
      r_bin_out <= w_bin_q;
      // The reset value of gray_q is not a real sample, so the first
      // edge after reset only primes the pipeline.
      r_primed  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SYNC;
      r_wrap  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = r_wrap;
    if (clr) begin
      w_state_nxt = SYNC;
      w_wrap_nxt  = '0;
    end else begin
      case (r_state)
        SYNC: begin
          if (r_primed) begin
            w_state_nxt = TRACK;
          end
        end
        TRACK: begin
          if (w_fault) begin
            w_state_nxt = FAULT;
          end else if (w_wrap_evt && (r_wrap != '1)) begin
            w_wrap_nxt = r_wrap + c_WRAP_INC;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = SYNC;
        end
      endcase
    end
  end

  assign bin_out  = r_bin_out;
  assign valid    = (r_state == TRACK);
  assign err      = (r_state == FAULT);
  assign wrap_cnt = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_gray_monitor                                           |
// | Description : Directed self-checking bench for gray_monitor (CBITS=4,   |
// |               WBITS=2) with a reference model of the monitor rules.     |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_gray_monitor;

  localparam int CB   = 4;
  localparam int WB   = 2;
  localparam int MODN = 16;
  localparam int WMAX = 3;

  logic          clk;
  logic          rst;
  logic [CB-1:0] gray_in;
  logic          sig_in;
  logic          clr;
  logic [CB-1:0] bin_out;
  logic          valid;
  logic          err;
  logic [WB-1:0] wrap_cnt;

  int checks;
  int errors;

  gray_monitor #(.CBITS(CB), .WBITS(WB)) dut (
    .clk      (clk),
    .rst      (rst),
    .gray_in  (gray_in),
    .sig_in   (sig_in),
    .clr      (clr),
    .bin_out  (bin_out),
    .valid    (valid),
    .err      (err),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  // Binary value of a Gray code by folding shifted copies.
  function automatic int g2b(input int g);
    int b;
    b = 0;
    for (int k = g; k != 0; k = k >> 1) b = b ^ k;
    return b;
  endfunction

  function automatic bit pair_ok(input int q, input int p, input bit sq);
    int bq;
    int bp;
    bq = g2b(q);
    bp = g2b(p);
    if (sq != (q == 0)) return 1'b0;
    return (bq == bp) || (bq == (bp + 1) % MODN);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a compliant monitor shows after each edge.
  int m_q, m_p, m_bin, m_wrap;
  bit m_sq, m_valid, m_err, m_primed;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= 0; m_p <= 0; m_sq <= 0; m_bin <= 0;
      m_valid <= 0; m_err <= 0; m_wrap <= 0; m_primed <= 0;
    end else begin
      m_q      <= int'(gray_in);
      m_p      <= m_q;
      m_sq     <= sig_in;
      m_bin    <= g2b(m_q);
      m_primed <= 1'b1;
      if (clr) begin
        m_valid <= 0; m_err <= 0; m_wrap <= 0;
      end else if (m_valid) begin
        if (!pair_ok(m_q, m_p, m_sq)) begin
          m_valid <= 0; m_err <= 1;
        end else if (m_sq && m_p != 0 && m_wrap < WMAX) begin
          m_wrap <= m_wrap + 1;
        end
      end else if (!m_err && m_primed) begin
        m_valid <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_bin_out",  int'(bin_out),  m_bin);
      check("model_valid",    int'(valid),    int'(m_valid));
      check("model_err",      int'(err),      int'(m_err));
      check("model_wrap_cnt", int'(wrap_cnt), m_wrap);
    end
  end

  task automatic step(input int g, input bit s, input bit c);
    @(negedge clk);
    gray_in = CB'(g);
    sig_in  = s;
    clr     = c;
  endtask

  task automatic count_wrap();
    for (int i = 1; i < MODN; i++) step(b2g(i), 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_exp [5];
    sat_exp = '{1, 2, 3, 3, 3};
    checks = 0;
    errors = 0;
    rst = 1'b1; clr = 1'b0; gray_in = '0; sig_in = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_bin_out", int'(bin_out), 0);
    check("reset_valid",   int'(valid),   0);
    check("reset_err",     int'(err),     0);
    check("reset_wrap",    int'(wrap_cnt), 0);
    rst = 1'b0;

    // SYNC for one edge after reset, then TRACK
    step(0, 1, 0);
    check("post_reset_edge1_valid", int'(valid), 0);
    step(0, 1, 0);
    check("post_reset_edge2_valid", int'(valid), 1);

    // legal count 1..15 then wrap to 0
    for (int i = 1; i < MODN; i++) begin
      step(b2g(i), 0, 0);
      if (i == 9) check("count_bin_latency", int'(bin_out), 7);
    end
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("count_wrap_one", int'(wrap_cnt), 1);
    check("count_no_err",   int'(err),      0);

    // hold at 0101 (bin 6)
    for (int i = 1; i <= 5; i++) step(b2g(i), 0, 0);
    repeat (5) step(4'b0101, 0, 0);
    step(b2g(7), 0, 0);
    check("hold_valid",   int'(valid),    1);
    check("hold_wrap",    int'(wrap_cnt), 1);
    check("hold_bin_out", int'(bin_out),  6);

    // continue to a second wrap, then jump 0001 -> 0010
    for (int i = 8; i < MODN; i++) step(b2g(i), 0, 0);
    step(0, 1, 0);
    step(4'b0001, 0, 0);
    step(4'b0010, 0, 0);
    check("jump_err_not_yet", int'(err),      0);
    check("jump_wrap_two",    int'(wrap_cnt), 2);
    step(b2g(4), 0, 0);
    step(b2g(5), 0, 0);
    check("jump_err_set", int'(err), 1);
    for (int i = 6; i < MODN; i++) step(b2g(i), 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("fault_wrap_frozen", int'(wrap_cnt), 2);
    check("fault_err_sticky",  int'(err),      1);
    check("fault_valid_low",   int'(valid),    0);

    // clear
    step(0, 1, 1);
    step(0, 1, 0);
    check("clr_valid", int'(valid),    0);
    check("clr_err",   int'(err),      0);
    check("clr_wrap",  int'(wrap_cnt), 0);
    step(b2g(1), 0, 0);
    check("clr_valid_back", int'(valid), 1);

    // sig high on a nonzero count
    step(4'b0011, 1, 0);
    step(b2g(3), 0, 0);
    step(b2g(4), 0, 0);
    check("sig_high_nonzero_err", int'(err), 1);
    step(b2g(5), 0, 1);
    for (int i = 6; i < MODN; i++) step(b2g(i), 0, 0);
    check("sig_clr_ok", int'(err), 0);
    // sig low on zero
    step(0, 0, 0);
    step(b2g(1), 0, 0);
    step(b2g(2), 0, 0);
    check("sig_low_zero_err", int'(err), 1);

    // saturation
    step(0, 1, 1);
    step(0, 1, 0);
    for (int w = 0; w < 5; w++) begin
      count_wrap();
      check($sformatf("sat_wrap_%0d", w), int'(wrap_cnt), sat_exp[w]);
    end

    // reset mid-run with wrap_cnt = 2
    step(0, 1, 1);
    step(0, 1, 0);
    count_wrap();
    count_wrap();
    step(b2g(1), 0, 0);
    step(b2g(2), 0, 0);
    step(b2g(3), 0, 0);
    check("prerst_wrap", int'(wrap_cnt), 2);
    check("prerst_err",  int'(err),      0);
    check("prerst_bin",  int'(bin_out),  1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bin",   int'(bin_out),  0);
    check("async_rst_valid", int'(valid),    0);
    check("async_rst_err",   int'(err),      0);
    check("async_rst_wrap",  int'(wrap_cnt), 0);
    @(negedge clk);
    rst = 1'b0; gray_in = CB'(b2g(9)); sig_in = 1'b0; clr = 1'b0;
    step(b2g(10), 0, 0);
    check("rst2_edge1_valid", int'(valid), 0);
    step(b2g(11), 0, 0);
    check("rst2_edge2_valid", int'(valid), 1);
    for (int i = 12; i < MODN; i++) step(b2g(i), 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("rst2_no_err", int'(err),      0);
    check("rst2_wrap",   int'(wrap_cnt), 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
